dec_onehot_decoder: RTL and testbench

DEC_ONEHOT_DECODER -- requirements
Module: dec_onehot_decoder

---
 rtl/dec_onehot_decoder.sv | 134 +++++++++++++
 tb/tb_dec_onehot_decoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dec_onehot_decoder.sv
// dec_onehot_decoder: 5-to-32 one-hot decoder with a two-slot output buffer
// and a sticky OR-accumulated mask of every decoded word that was accepted.
// Ready/valid on both sides.
// The mask and dup path is independent of buffer occupancy.

module dec_onehot_decoder #(
  parameter int DEPTH = 2  // buffer slots; the slot logic below is written for exactly 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  A,
  input  logic        en,
  input  logic        mask_clr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Y,
  output logic [31:0] mask,
  output logic        mask_full,
  output logic        dup,
  output logic [1:0]  fill
);

  // Occupancy doubles as the FSM state: the encoding equals the fill count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam logic [1:0] FULL_FILL = 2'(DEPTH);

  state_e      state_q, state_d;
  logic [31:0] slot0_q, slot0_d;  // head (oldest entry)
  logic [31:0] slot1_q, slot1_d;  // second entry, valid only in TWO
  logic [31:0] mask_q, mask_d;
  logic        dup_q, dup_d;

  logic        accept;
  logic        pop;
  logic [31:0] entry;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  assign entry  = en ? (32'd1 << A) : 32'd0;

  // State register: synchronous active-low reset returns the buffer to EMPTY.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and slot-data logic for the two-entry FIFO (slot0 is the head).
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned, which would infer a latch.
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          slot0_d = entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          slot0_d = entry;
        end else if (accept) begin
          slot1_d = entry;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only a pop can happen.
        if (pop) begin
          slot0_d = slot1_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Output decode from the registered state only.
  always_comb begin
    fill      = state_q;
    in_ready  = (state_q != FULL_FILL);
    out_valid = (state_q != EMPTY);
    Y         = (state_q != EMPTY) ? slot0_q : 32'd0;
  end

  // Slot storage: payload only, qualified by the state, so it carries no reset.
  always_ff @(posedge clk) begin
    // NOTE: the data slots are deliberately not reset; Y is forced to zero
    // whenever the buffer is EMPTY, so stale slot contents are never visible.
    slot0_q <= slot0_d;
    slot1_q <= slot1_d;
  end

  // Mask next value: clear first, then OR in the accepted one-hot word.
  always_comb begin
    mask_d = mask_clr ? 32'd0 : mask_q;
    if (accept && en) begin
      mask_d = mask_d | entry;
    end
    dup_d = accept && en && !mask_clr && mask_q[A];
  end

  // Mask and duplicate-pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= 32'd0;
      dup_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      dup_q  <= dup_d;
    end
  end

  assign mask      = mask_q;
  assign mask_full = &mask_q;
  assign dup       = dup_q;

endmodule

// File: tb/tb_dec_onehot_decoder.sv
// Testbench for dec_onehot_decoder: directed vectors, scoreboard queue of
// expected Y words filled on accept and drained by a monitor on pop.

module tb_dec_onehot_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  A;
  logic        en;
  logic        mask_clr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Y;
  logic [31:0] mask;
  logic        mask_full;
  logic        dup;
  logic [1:0]  fill;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model_mask;

  dec_onehot_decoder #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .en        (en),
    .mask_clr  (mask_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .mask      (mask),
    .mask_full (mask_full),
    .dup       (dup),
    .fill      (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver side of the scoreboard: record the expected word of every accept.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(en ? (32'd1 << A) : 32'd0);
    end
  end

  // Monitor: every pop must deliver the oldest outstanding expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected: got %h, expected no output", Y);
      end else begin
        check("pop_Y", Y, exp_q.pop_front());
      end
    end
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    A         = 5'd0;
    en        = 1'b0;
    mask_clr  = 1'b0;
    out_ready = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_fill",      32'(fill), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_Y",         Y, 32'd0);
    check("rst_in_ready",  32'(in_ready), 32'd1);
    check("rst_mask",      mask, 32'd0);
    check("rst_mask_full", 32'(mask_full), 32'd0);
    check("rst_dup",       32'(dup), 32'd0);

    // First accept on the first edge out of reset, one-cycle latency.
    rst_n = 1'b1; in_valid = 1'b1; A = 5'd5; en = 1'b1; out_ready = 1'b1;
    tick();
    check("a5_Y",         Y, 32'h0000_0020);
    check("a5_out_valid", 32'(out_valid), 32'd1);
    check("a5_mask",      mask, 32'h0000_0020);
    check("a5_dup",       32'(dup), 32'd0);
    in_valid = 1'b0;
    tick();
    check("a5_drained_fill", 32'(fill), 32'd0);

    // Back-pressure: two entries fill the buffer, third waits.
    out_ready = 1'b0; in_valid = 1'b1; A = 5'd0;
    tick();
    check("bp_fill1", 32'(fill), 32'd1);
    A = 5'd31;
    tick();
    check("bp_fill2",     32'(fill), 32'd2);
    check("bp_in_ready0", 32'(in_ready), 32'd0);
    A = 5'd7;
    tick();
    check("bp_hold_fill", 32'(fill), 32'd2);
    check("bp_hold_Y",    Y, 32'h0000_0001);
    check("bp_hold_rdy",  32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();  // pop only: TWO never accepts
    check("bp_pop1_fill", 32'(fill), 32'd1);
    check("bp_pop1_Y",    Y, 32'h8000_0000);
    tick();  // accept 7 with simultaneous pop
    check("bp_pop2_fill", 32'(fill), 32'd1);
    check("bp_pop2_Y",    Y, 32'h0000_0080);
    in_valid = 1'b0;
    tick();
    check("bp_empty_fill", 32'(fill), 32'd0);
    check("bp_mask",       mask, 32'h8000_00A1);

    // Clear with no accept.
    mask_clr = 1'b1;
    tick();
    check("clr_mask", mask, 32'd0);
    mask_clr = 1'b0;

    // Duplicate detection on index 9.
    in_valid = 1'b1; A = 5'd9; en = 1'b1;
    tick();
    check("dup9_first", 32'(dup), 32'd0);
    tick();
    check("dup9_second", 32'(dup), 32'd1);
    in_valid = 1'b0;
    tick();
    check("dup9_after", 32'(dup), 32'd0);
    check("dup9_mask",  mask, 32'h0000_0200);

    // All 32 indices accepted with an independent mask model.
    model_mask = 32'h0000_0200;
    in_valid = 1'b1; en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      A = 5'(i);
      tick();
      check($sformatf("all_dup_%0d", i), 32'(dup), 32'(model_mask[i]));
      model_mask[i] = 1'b1;
    end
    check("all_mask",      mask, 32'hFFFF_FFFF);
    check("all_mask_full", 32'(mask_full), 32'd1);
    A = 5'd31;
    tick();
    check("sat_mask", mask, 32'hFFFF_FFFF);
    check("sat_dup",  32'(dup), 32'd1);
    mask_clr = 1'b1; A = 5'd3;
    tick();
    check("clrset_mask", mask, 32'h0000_0008);
    check("clrset_full", 32'(mask_full), 32'd0);
    check("clrset_dup",  32'(dup), 32'd0);
    mask_clr = 1'b0; in_valid = 1'b0;
    tick();

    // en=0 accept: zero word buffered, mask untouched.
    out_ready = 1'b0; in_valid = 1'b1; A = 5'd12; en = 1'b0;
    tick();
    check("en0_out_valid", 32'(out_valid), 32'd1);
    check("en0_Y",         Y, 32'd0);
    check("en0_mask",      mask, 32'h0000_0008);
    check("en0_dup",       32'(dup), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("en0_drained", 32'(fill), 32'd0);

    // Reset while full discards both entries.
    out_ready = 1'b0; in_valid = 1'b1; en = 1'b1; A = 5'd1;
    tick();
    A = 5'd2;
    tick();
    check("prerst_fill", 32'(fill), 32'd2);
    rst_n = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    tick();
    check("midrst_fill",      32'(fill), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_mask",      mask, 32'd0);
    check("midrst_in_ready",  32'(in_ready), 32'd1);
    check("midrst_Y",         Y, 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    tick();
    check("postrst_out_valid", 32'(out_valid), 32'd0);
    check("postrst_Y",         Y, 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
